mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle load/store sequencer between the execute stage and the data memory port. It takes one decoded memory operation (store flag, funct3, effective address, rs2 data) and generates byte enables and replicated write data for stores. For loads it extracts and sign/zero-extends the read data. It drives a req/ready handshake to memory and holds `busy` high so the core stalls until the access completes, faults or times out.

## Interface
Parameters:
- `WAIT_MAX`, 255: maximum cycles `mem_req` stays high without `mem_ready` before a timeout fault (1..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request from execute; ignored while `busy`.
- `is_store`  in  1  1 = store, 0 = load; sampled with `start`.
- `funct3`  in  3  RV32I width/sign field; sampled with `start`.
- `addr`  in  32  effective byte address; sampled with `start`.
- `wdata`  in  32  rs2 value; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` until `done` inclusive.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; valid only with `done` for a fault-free load, otherwise 0.
- `err_code`  out  2  valid with `done`: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  4  byte write enables; 0000 for loads.
- `mem_addr`  out  32  word address: {addr[31:2],2'b00}.
- `mem_wdata`  out  32  replicated store data.
- `mem_ready`  in  1  memory accept/response; for loads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE + `start`: latch the inputs and check them.
  - Illegal funct3 → RESP with code 10. Legal values: loads 000/001/010/100/101; stores 000/001/010.
  - Misaligned → RESP with code 01. Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Otherwise → ACCESS and clear the wait counter.
- ACCESS: `mem_req`=1 and `mem_addr`/`mem_we`/`mem_wdata` held stable.
  - `mem_ready` → RESP; for loads, capture the extracted `mem_rdata`.
  - Counter reaches `WAIT_MAX` with no `mem_ready` → RESP with code 11; drop `mem_req`.
- RESP: `done`=1 for one cycle → IDLE.
- Byte enables:
  - sw: 1111.
  - sh: addr[1]=0 → 0011, addr[1]=1 → 1100.
  - sb: addr[1:0] 00/01/10/11 → 0001/0010/0100/1000.
- Write data: sb → {4{wdata[7:0]}}; sh → {2{wdata[15:0]}}; sw → wdata.
- Load extract: select the byte by addr[1:0], or the halfword by addr[1]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- On a fault, no memory access occurs (codes 01/10) or the access is abandoned (code 11). `rdata`=0.
- `mem_ready` outside ACCESS is ignored. `start` while not IDLE is ignored.

## Timing
- All outputs are registered. Reset values: `busy`, `done`, `mem_req`=0; `mem_we`=0000; `rdata`, `mem_addr`, `mem_wdata`=0; `err_code`=00.
- `start` at cycle 0 → `mem_req` and `busy` high at cycle 1.
- `mem_ready` at cycle k ≥ 1 → `mem_req` low and `done` high at cycle k+1; `busy` falls at k+2.
- Minimum latency from `start` to `done` is 2 cycles (ready at cycle 1).
- Fault decided at `start`: `done` at cycle 1 with no `mem_req`.
- Timeout: `mem_req` high for exactly `WAIT_MAX` cycles, then `done` with code 11.
- A new `start` is accepted in the cycle after `done`.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous), including `mem_req` and `mem_we`; any pending access is discarded.

## Structure
- Package `riscv_mem_pkg`: funct3 constants (F3_B/H/W/BU/HU), FSM state enum, err_code constants.
- Sub-module `mem_align` (combinational): byte-enable generation, write-data replication and load extract/extend. It is instantiated once. The FSM, latches and wait counter stay in the top.

## Test plan
- sb: addr=0x1003, wdata=0x000000A5, ready at cycle 1 → `mem_we`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000, `done` at cycle 2 with err 00.
- lb: addr=0x2001, `mem_rdata`=0x0000_80FF, ready after 3 wait cycles → `rdata`=0xFFFFFF80. Same with lhu at addr=0x2002 and `mem_rdata`=0xBEEF0000 → `rdata`=0x0000BEEF.
- sw at addr=0x3002 → `done` at cycle 1 with err 01, `mem_req` never asserted. Load with funct3=011 → err 10.
- `WAIT_MAX`=4, `mem_ready` held 0 → `mem_req` high for exactly 4 cycles, then `done` with err 11 and `rdata`=0.
- `rst` pulsed during ACCESS → `mem_req`/`busy` drop the same cycle. A later lw with immediate ready completes normally. A `start` pulse while `busy` is ignored.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, FSM states,
// completion codes and the request legality checks.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Unsigned loads have no store counterpart, so they are legal only for loads.
    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~st;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   misaligned = lo[0];
            2'b10:   misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables, store data replication and
// load byte/halfword extraction with sign or zero extension.
module mem_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lane selection and data replication.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        byte_s    = 8'h00;
        rdata_ext = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            2'b11:   byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            F3_BU:   rdata_ext = {24'h00_0000, byte_s};
            F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            F3_HU:   rdata_ext = {16'h0000, half_s};
            F3_W:    rdata_ext = mem_rdata;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: validates a memory operation, drives a req/ready access
// with a bounded wait, and reports completion with a one-cycle done pulse.
module mem_access_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_r, state_s;
    logic        is_store_r, is_store_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [1:0]  addr_lo_r, addr_lo_s;
    logic [7:0]  cnt_r, cnt_s;

    logic        busy_s, done_s, mem_req_s;
    logic [31:0] rdata_s, mem_addr_s, mem_wdata_s;
    logic [1:0]  err_s;
    logic [3:0]  mem_we_s;

    logic [2:0]  sel_f3_s;
    logic [1:0]  sel_lo_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s, rdata_ext_s;

    // In IDLE the lanes are computed from the live request so the outputs are ready next cycle.
    assign sel_f3_s = (state_r == ST_IDLE) ? funct3    : funct3_r;
    assign sel_lo_s = (state_r == ST_IDLE) ? addr[1:0] : addr_lo_r;

    mem_align u_align (
        .funct3    (sel_f3_s),
        .addr_lo   (sel_lo_s),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        is_store_s  = is_store_r;
        funct3_s    = funct3_r;
        addr_lo_s   = addr_lo_r;
        cnt_s       = cnt_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        rdata_s     = 32'h0000_0000;
        err_s       = ERR_OK;
        mem_req_s   = 1'b0;
        mem_we_s    = 4'b0000;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    is_store_s = is_store;
                    funct3_s   = funct3;
                    addr_lo_s  = addr[1:0];
                    busy_s     = 1'b1;
                    if (!f3_legal(is_store, funct3)) begin
                        state_s = ST_RESP;
                        done_s  = 1'b1;
                        err_s   = ERR_FUNCT3;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        state_s = ST_RESP;
                        done_s  = 1'b1;
                        err_s   = ERR_MISALIGN;
                    end else begin
                        state_s    = ST_ACCESS;
                        cnt_s      = 8'd0;
                        mem_req_s  = 1'b1;
                        mem_addr_s = {addr[31:2], 2'b00};
                        if (is_store) begin
                            mem_we_s    = be_s;
                            mem_wdata_s = wdata_rep_s;
                        end else begin
                            mem_we_s    = 4'b0000;
                            mem_wdata_s = 32'h0000_0000;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy_s = 1'b1;
                if (mem_ready) begin
                    state_s = ST_RESP;
                    done_s  = 1'b1;
                    if (is_store_r) begin
                        rdata_s = 32'h0000_0000;
                    end else begin
                        rdata_s = rdata_ext_s;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_RESP;
                    done_s  = 1'b1;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    cnt_s     = cnt_r + 8'd1;
                    mem_req_s = 1'b1;
                    mem_we_s  = mem_we;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            is_store_r <= 1'b0;
            funct3_r   <= 3'b000;
            addr_lo_r  <= 2'b00;
            cnt_r      <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 32'h0000_0000;
            err_code   <= ERR_OK;
            mem_req    <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            is_store_r <= is_store_s;
            funct3_r   <= funct3_s;
            addr_lo_r  <= addr_lo_s;
            cnt_r      <= cnt_s;
            busy       <= busy_s;
            done       <= done_s;
            rdata      <= rdata_s;
            err_code   <= err_s;
            mem_req    <= mem_req_s;
            mem_we     <= mem_we_s;
            mem_addr   <= mem_addr_s;
            mem_wdata  <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed operations push expected
// completions; a negedge monitor checks requests and done responses.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, mem_req;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [3:0]  mem_we;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    typedef struct {
        logic        st;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  err;
        logic [31:0] rd;
        int          reqc;
        int          lat;
        int          sc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int reqcnt = 0;

    mem_access_ctrl #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err_code(err_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks the first request cycle and every done pulse against the queue head.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            reqcnt = 0;
        end else begin
            if (mem_req) begin
                if (reqcnt == 0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_req", {31'd0, mem_req}, 32'd0);
                    end else begin
                        chk("mem_we", {28'd0, mem_we}, {28'd0, q[0].we});
                        chk("mem_addr", mem_addr, q[0].addr);
                        if (q[0].st) chk("mem_wdata", mem_wdata, q[0].wd);
                    end
                end
                reqcnt++;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("err_code", {30'd0, err_code}, {30'd0, e.err});
                    chk("rdata", rdata, e.rd);
                    chk("req_cycles", reqcnt, e.reqc);
                    chk("latency", cyc - e.sc, e.lat);
                    chk("busy_at_done", {31'd0, busy}, 32'd1);
                end
                reqcnt = 0;
            end
        end
    end

    task automatic drain();
        int i;
        for (i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (i == 40) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ewe, input logic [31:0] ewd,
                         input logic [1:0] eerr, input logic [31:0] erd, input int ereqc,
                         input int elat);
        exp_t e;
        @(negedge clk);
        e.st = st; e.we = ewe; e.addr = {a[31:2], 2'b00}; e.wd = ewd;
        e.err = eerr; e.rd = erd; e.reqc = ereqc; e.lat = elat; e.sc = cyc;
        q.push_back(e);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ready_after(input int d, input logic [31:0] rw);
        if (d >= 0) begin
            repeat (d) @(negedge clk);
            mem_ready = 1'b1; mem_rdata = rw;
            @(negedge clk);
            mem_ready = 1'b0; mem_rdata = 32'h0;
        end
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] rw,
                          input logic [3:0] ewe, input logic [31:0] ewd, input logic [1:0] eerr,
                          input logic [31:0] erd, input int ereqc, input int elat);
        issue(st, f3, a, wd, ewe, ewd, eerr, erd, ereqc, elat);
        ready_after(d, rw);
        drain();
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {28'd0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //     st    f3      addr          wdata         d   mem_rdata     we       exp wdata     err    exp rdata   rq lat
        run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0,        4'b1000, 32'hA5A5_A5A5, 2'b00, 32'h0,        1, 2);
        run_op(1'b0, 3'b000, 32'h0000_2001, 32'h0,         3, 32'h0000_80FF, 4'b0000, 32'h0,        2'b00, 32'hFFFF_FF80, 4, 5);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0,         1, 32'hBEEF_0000, 4'b0000, 32'h0,        2'b00, 32'h0000_BEEF, 2, 3);
        run_op(1'b1, 3'b010, 32'h0000_3002, 32'h1111_2222, -1, 32'h0,       4'b0000, 32'h0,        2'b01, 32'h0,        0, 1);
        run_op(1'b0, 3'b011, 32'h0000_4000, 32'h0,         -1, 32'h0,       4'b0000, 32'h0,        2'b10, 32'h0,        0, 1);
        run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0,         -1, 32'h0,       4'b0000, 32'h0,        2'b11, 32'h0,        4, 5);
        run_op(1'b1, 3'b001, 32'h0000_6002, 32'h1234_5678, 0, 32'h0,        4'b1100, 32'h5678_5678, 2'b00, 32'h0,        1, 2);
        run_op(1'b0, 3'b001, 32'h0000_7000, 32'h0,         2, 32'h1234_F00D, 4'b0000, 32'h0,        2'b00, 32'hFFFF_F00D, 3, 4);
        run_op(1'b0, 3'b100, 32'h0000_7003, 32'h0,         0, 32'h9A00_0000, 4'b0000, 32'h0,        2'b00, 32'h0000_009A, 1, 2);
        run_op(1'b1, 3'b100, 32'h0000_8000, 32'h0000_0011, -1, 32'h0,       4'b0000, 32'h0,        2'b10, 32'h0,        0, 1);
        run_op(1'b0, 3'b001, 32'h0000_9001, 32'h0,         -1, 32'h0,       4'b0000, 32'h0,        2'b01, 32'h0,        0, 1);
        run_op(1'b1, 3'b000, 32'h0000_8001, 32'h0000_003C, 0, 32'h0,        4'b0010, 32'h3C3C_3C3C, 2'b00, 32'h0,        1, 2);
        run_op(1'b0, 3'b010, 32'h0000_8000, 32'h0,         3, 32'hDEAD_BEEF, 4'b0000, 32'h0,        2'b00, 32'hDEAD_BEEF, 4, 5);

        // Reset in the middle of an access discards it.
        issue(1'b1, 3'b010, 32'h0000_A000, 32'h5555_AAAA, 4'b1111, 32'h5555_AAAA, 2'b00, 32'h0, 1, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_we", {28'd0, mem_we}, 32'd0);
        void'(q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 3'b010, 32'h0000_A004, 32'h0, 0, 32'h0BAD_F00D, 4'b0000, 32'h0, 2'b00, 32'h0BAD_F00D, 1, 2);

        // A start while busy must not disturb the access in flight.
        issue(1'b0, 3'b010, 32'h0000_B000, 32'h0, 4'b0000, 32'h0, 2'b00, 32'hCAFE_F00D, 3, 4);
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_C000; wdata = 32'h7777_7777;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_addr", mem_addr, 32'h0000_B000);
        chk("ignore_we", {28'd0, mem_we}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'h0;
        drain();
        repeat (4) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("q_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
